// File: rtl/room_controller.sv
// Room sequencer for a 2x2 map grid: detects doorway exits, fades the screen
// out, swaps the active room, hands a spawn point to player logic, then fades back in.
module room_controller #(
   parameter int DOOR_LO = 260,
   parameter int DOOR_HI = 380,
   parameter int SIDE_LO = 200,
   parameter int SIDE_HI = 280
) (
   input  logic       clk_vga,
   input  logic       reset,
   input  logic [9:0] CurrentX,
   input  logic [8:0] CurrentY,
   input  logic [9:0] playerX,
   input  logic [8:0] playerY,
   input  logic [7:0] mapData0,
   input  logic [7:0] mapData1,
   input  logic [7:0] mapData2,
   input  logic [7:0] mapData3,
   input  logic       spawn_ack,
   output logic [1:0] roomSel,
   output logic [7:0] wall,
   output logic [7:0] pixelOut,
   output logic [9:0] spawnX,
   output logic [8:0] spawnY,
   output logic       spawn_valid,
   output logic       freeze
);

   typedef enum logic [1:0] {PLAY, FADE_OUT, SWAP, FADE_IN} stateType;
   typedef enum logic [1:0] {DIR_N, DIR_S, DIR_E, DIR_W} dirType;

   localparam logic [9:0] doorLo = DOOR_LO[9:0];
   localparam logic [9:0] doorHi = DOOR_HI[9:0];
   localparam logic [8:0] sideLo = SIDE_LO[8:0];
   localparam logic [8:0] sideHi = SIDE_HI[8:0];

   stateType   state;
   dirType     dir;
   dirType     exitDir;
   logic [1:0] level;
   logic [1:0] target;
   logic [1:0] exitTarget;
   logic       exitValid;
   logic       prevOrigin;
   logic       atOrigin;
   logic       frameTick;
   logic       xWin;
   logic       yWin;
   logic [7:0] mapSel;

   function automatic logic [7:0] fadePixel(input logic [7:0] pix, input logic [1:0] lvl);
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
      r = pix[7:5] >> lvl;
      g = pix[4:2] >> lvl;
      if (lvl == 2'd0) b = pix[1:0];
      else if (lvl == 2'd1) b = {1'b0, pix[1]};
      else b = 2'b00;
      if (lvl == 2'd3) fadePixel = 8'h00;
      else fadePixel = {r, g, b};
   endfunction

   function automatic logic [7:0] wallColour(input logic [1:0] room);
      case (room)
         2'd0:    wallColour = 8'h49;
         2'd1:    wallColour = 8'h6D;
         2'd2:    wallColour = 8'h92;
         default: wallColour = 8'h24;
      endcase
   endfunction

   // Arrival point sits just inside the doorway opposite the one used to leave.
   function automatic logic [18:0] spawnFor(input dirType d);
      case (d)
         DIR_N:   spawnFor = {10'd320, 9'd420};
         DIR_S:   spawnFor = {10'd320, 9'd60};
         DIR_E:   spawnFor = {10'd60, 9'd240};
         default: spawnFor = {10'd580, 9'd240};
      endcase
   endfunction

   assign atOrigin  = (CurrentX == 10'd0) && (CurrentY == 9'd0);
   assign frameTick = atOrigin && !prevOrigin;
   assign xWin      = (playerX >= doorLo) && (playerX < doorHi);
   assign yWin      = (playerY >= sideLo) && (playerY < sideHi);

   // Exit detection, N > S > E > W; doorways leading off the grid never match.
   always_comb begin
      exitValid  = 1'b0;
      exitTarget = roomSel;
      exitDir    = DIR_N;
      if ((playerY < 9'd40) && xWin && roomSel[1]) begin
         exitValid  = 1'b1;
         exitTarget = {1'b0, roomSel[0]};
         exitDir    = DIR_N;
      end else if ((playerY >= 9'd440) && xWin && !roomSel[1]) begin
         exitValid  = 1'b1;
         exitTarget = {1'b1, roomSel[0]};
         exitDir    = DIR_S;
      end else if ((playerX > 10'd600) && yWin && !roomSel[0]) begin
         exitValid  = 1'b1;
         exitTarget = {roomSel[1], 1'b1};
         exitDir    = DIR_E;
      end else if ((playerX < 10'd40) && yWin && roomSel[0]) begin
         exitValid  = 1'b1;
         exitTarget = {roomSel[1], 1'b0};
         exitDir    = DIR_W;
      end else begin
         exitValid  = 1'b0;
      end
   end

   // Map source for the active room.
   always_comb begin
      case (roomSel)
         2'd0:    mapSel = mapData0;
         2'd1:    mapSel = mapData1;
         2'd2:    mapSel = mapData2;
         default: mapSel = mapData3;
      endcase
   end

   // Frame-start history and registered colour outputs.
   always_ff @(posedge clk_vga) begin
      if (reset) begin
         prevOrigin <= 1'b0;
         pixelOut   <= 8'h00;
         wall       <= 8'h49;
      end else begin
         prevOrigin <= atOrigin;
         pixelOut   <= fadePixel(mapSel, level);
         wall       <= wallColour(roomSel);
      end
   end

   // Transition sequencer; freeze tracks whether the next state leaves PLAY.
   always_ff @(posedge clk_vga) begin
      if (reset) begin
         state       <= PLAY;
         level       <= 2'd0;
         roomSel     <= 2'd0;
         target      <= 2'd0;
         dir         <= DIR_N;
         spawnX      <= 10'd0;
         spawnY      <= 9'd0;
         spawn_valid <= 1'b0;
         freeze      <= 1'b0;
      end else begin
         case (state)
            PLAY: begin
               if (frameTick && exitValid) begin
                  state  <= FADE_OUT;
                  level  <= 2'd1;
                  target <= exitTarget;
                  dir    <= exitDir;
                  freeze <= 1'b1;
               end else begin
                  freeze <= 1'b0;
               end
            end
            FADE_OUT: begin
               freeze <= 1'b1;
               // The tick that brings the screen fully dark also swaps the room.
               if (frameTick && (level >= 2'd2)) begin
                  state            <= SWAP;
                  level            <= 2'd3;
                  roomSel          <= target;
                  {spawnX, spawnY} <= spawnFor(dir);
                  spawn_valid      <= 1'b1;
               end else if (frameTick) begin
                  level <= level + 2'd1;
               end else begin
                  level <= level;
               end
            end
            SWAP: begin
               freeze <= 1'b1;
               if (spawn_ack && spawn_valid) begin
                  spawn_valid <= 1'b0;
                  state       <= FADE_IN;
               end else begin
                  spawn_valid <= spawn_valid;
               end
            end
            FADE_IN: begin
               if (frameTick && (level == 2'd0)) begin
                  state  <= PLAY;
                  freeze <= 1'b0;
               end else if (frameTick) begin
                  level  <= level - 2'd1;
                  freeze <= 1'b1;
               end else begin
                  freeze <= 1'b1;
               end
            end
            default: begin
               state  <= PLAY;
               freeze <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_room_controller.sv
// Directed scenarios followed by randomized traffic, all checked against a
// frame-level behavioural model of the room sequencer.
module tb_room_controller;

   logic       clk_vga = 1'b0;
   logic       reset;
   logic [9:0] CurrentX;
   logic [8:0] CurrentY;
   logic [9:0] playerX;
   logic [8:0] playerY;
   logic [7:0] mapData0, mapData1, mapData2, mapData3;
   logic       spawn_ack;
   logic [1:0] roomSel;
   logic [7:0] wall;
   logic [7:0] pixelOut;
   logic [9:0] spawnX;
   logic [8:0] spawnY;
   logic       spawn_valid;
   logic       freeze;

   int checks = 0;
   int fails  = 0;

   // model: phase 0 playing, 1 darkening, 2 awaiting ack, 3 brightening
   int mPhase = 0, mLevel = 0, mRoom = 0, mTarget = 0, mDir = 0;
   int mSx = 0, mSy = 0, mValid = 0, mPrevOrigin = 0, mPix = 0, mWall = 'h49, mFreeze = 0;
   int spX[4] = '{320, 320, 60, 580};
   int spY[4] = '{420, 60, 240, 240};
   int holdOk;

   room_controller dut (
      .clk_vga(clk_vga), .reset(reset), .CurrentX(CurrentX), .CurrentY(CurrentY),
      .playerX(playerX), .playerY(playerY), .mapData0(mapData0), .mapData1(mapData1),
      .mapData2(mapData2), .mapData3(mapData3), .spawn_ack(spawn_ack), .roomSel(roomSel),
      .wall(wall), .pixelOut(pixelOut), .spawnX(spawnX), .spawnY(spawnY),
      .spawn_valid(spawn_valid), .freeze(freeze)
   );

   always #5 clk_vga = ~clk_vga;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int fadeM(int pix, int lvl);
      int r, g, b, bl;
      if (lvl >= 3) return 0;
      r  = (pix / 32) % 8;
      g  = (pix / 4) % 8;
      b  = pix % 4;
      bl = (lvl < 2) ? lvl : 2;
      return (r / (1 << lvl)) * 32 + (g / (1 << lvl)) * 4 + b / (1 << bl);
   endfunction

   function automatic int wallM(int room);
      case (room)
         0: return 'h49;
         1: return 'h6D;
         2: return 'h92;
         default: return 'h24;
      endcase
   endfunction

   function automatic int mapOf(int room);
      case (room)
         0: return int'(mapData0);
         1: return int'(mapData1);
         2: return int'(mapData2);
         default: return int'(mapData3);
      endcase
   endfunction

   // Advance the model by one clock using the inputs currently applied.
   task automatic modelEdge();
      int px, py, row, col, hit, tgt, d, tick, origin, pixNext, wallNext;
      bit xw, yw;
      origin   = (CurrentX == 10'd0 && CurrentY == 9'd0) ? 1 : 0;
      tick     = (origin == 1 && mPrevOrigin == 0) ? 1 : 0;
      pixNext  = fadeM(mapOf(mRoom), mLevel);
      wallNext = wallM(mRoom);
      mPrevOrigin = origin;
      if (reset) begin
         mPhase = 0; mLevel = 0; mRoom = 0; mSx = 0; mSy = 0; mValid = 0;
         mPrevOrigin = 0; mPix = 0; mWall = 'h49; mFreeze = 0;
         return;
      end
      mPix = pixNext;
      mWall = wallNext;
      px = int'(playerX); py = int'(playerY);
      row = mRoom / 2; col = mRoom % 2;
      xw = (px >= 260 && px < 380);
      yw = (py >= 200 && py < 280);
      hit = 1; tgt = 0; d = 0;
      if (py < 40 && xw && row == 1) begin tgt = mRoom - 2; d = 0; end
      else if (py >= 440 && xw && row == 0) begin tgt = mRoom + 2; d = 1; end
      else if (px > 600 && yw && col == 0) begin tgt = mRoom + 1; d = 2; end
      else if (px < 40 && yw && col == 1) begin tgt = mRoom - 1; d = 3; end
      else hit = 0;
      case (mPhase)
         0: if (tick == 1 && hit == 1) begin
               mPhase = 1; mLevel = 1; mTarget = tgt; mDir = d;
            end
         1: if (tick == 1) begin
               mLevel++;
               if (mLevel == 3) begin
                  mPhase = 2; mRoom = mTarget; mSx = spX[mDir]; mSy = spY[mDir]; mValid = 1;
               end
            end
         2: if (spawn_ack && mValid == 1) begin mValid = 0; mPhase = 3; end
         default: if (tick == 1) begin
               if (mLevel == 0) mPhase = 0;
               else mLevel--;
            end
      endcase
      mFreeze = (mPhase != 0) ? 1 : 0;
   endtask

   task automatic step();
      modelEdge();
      @(posedge clk_vga);
      #1;
      check("m_roomSel", roomSel, mRoom);
      check("m_wall", wall, mWall);
      check("m_pixelOut", pixelOut, mPix);
      check("m_spawnX", spawnX, mSx);
      check("m_spawnY", spawnY, mSy);
      check("m_spawn_valid", spawn_valid, mValid);
      check("m_freeze", freeze, mFreeze);
   endtask

   task automatic tick();
      CurrentX = 10'd0; CurrentY = 9'd0;
      step();
      CurrentX = 10'd5; CurrentY = 9'd5;
      step();
   endtask

   initial begin
      reset = 1'b1; CurrentX = 10'd5; CurrentY = 9'd5; playerX = 10'd100; playerY = 9'd100;
      mapData0 = 8'hFF; mapData1 = 8'hFF; mapData2 = 8'hFF; mapData3 = 8'hFF; spawn_ack = 1'b0;
      step();
      check("rst_roomSel", roomSel, 2'd0);
      check("rst_wall", wall, 8'h49);
      check("rst_pixelOut", pixelOut, 8'h00);
      check("rst_spawn", {spawnX, spawnY}, 19'd0);
      check("rst_valid", spawn_valid, 1'b0);
      check("rst_freeze", freeze, 1'b0);
      reset = 1'b0; spawn_ack = 1'b1;
      step();
      spawn_ack = 1'b0;
      check("pix_lvl0", pixelOut, 8'hFF);
      check("stray_ack", freeze, 1'b0);

      // south exit from room 0
      playerX = 10'd320; playerY = 9'd450;
      tick();
      check("fo_freeze", freeze, 1'b1);
      check("pix_lvl1", pixelOut, 8'h6D);
      tick();
      check("pix_lvl2", pixelOut, 8'h24);
      tick();
      check("swap_room", roomSel, 2'd2);
      check("swap_spawn", {spawnX, spawnY}, {10'd320, 9'd60});
      check("swap_valid", spawn_valid, 1'b1);
      check("pix_lvl3", pixelOut, 8'h00);
      check("swap_wall", wall, 8'h92);

      holdOk = 1;
      for (int i = 0; i < 100; i++) begin
         if (i % 10 == 0) begin CurrentX = 10'd0; CurrentY = 9'd0; end
         else begin CurrentX = 10'd7; CurrentY = 9'd3; end
         step();
         if ({spawn_valid, spawnX, spawnY, roomSel} !== {1'b1, 10'd320, 9'd60, 2'd2}) holdOk = 0;
      end
      check("hold_stable", holdOk, 1);
      spawn_ack = 1'b1;
      step();
      spawn_ack = 1'b0;
      check("ack_valid", spawn_valid, 1'b0);
      check("fi_freeze", freeze, 1'b1);
      tick();
      check("fi_lvl2", pixelOut, 8'h24);
      tick();
      check("fi_lvl1", pixelOut, 8'h6D);
      tick();
      check("fi_lvl0", pixelOut, 8'hFF);
      check("fi_still_frozen", freeze, 1'b1);
      playerX = 10'd320; playerY = 9'd10;
      tick();
      check("play_freeze", freeze, 1'b0);
      repeat (3) step();
      check("exit_on_last_tick", freeze, 1'b0);
      tick();
      check("exit_later_tick", freeze, 1'b1);

      reset = 1'b1; step(); reset = 1'b0;
      playerX = 10'd320; playerY = 9'd10;
      repeat (3) tick();
      check("north_edge_freeze", freeze, 1'b0);
      check("north_edge_room", roomSel, 2'd0);
      playerX = 10'd610; playerY = 9'd240;
      repeat (3) tick();
      check("east_room", roomSel, 2'd1);
      check("east_spawn", {spawnX, spawnY}, {10'd60, 9'd240});
      spawn_ack = 1'b1; step(); spawn_ack = 1'b0;
      repeat (4) tick();
      check("room1_play", freeze, 1'b0);
      playerX = 10'd20; playerY = 9'd240;
      repeat (3) tick();
      check("west_room", roomSel, 2'd0);
      check("west_spawn", {spawnX, spawnY}, {10'd580, 9'd240});
      check("west_valid", spawn_valid, 1'b1);

      // reset lands while waiting for spawn_ack
      reset = 1'b1; step(); reset = 1'b0;
      check("swap_rst_room", roomSel, 2'd0);
      check("swap_rst_valid", spawn_valid, 1'b0);
      check("swap_rst_freeze", freeze, 1'b0);
      check("swap_rst_pix", pixelOut, 8'h00);

      playerX = 10'd320; playerY = 9'd450;
      CurrentX = 10'd0; CurrentY = 9'd0;
      repeat (5) step();
      CurrentX = 10'd5; CurrentY = 9'd5;
      repeat (3) step();
      check("held_origin_freeze", freeze, 1'b1);
      check("held_origin_level1", pixelOut, 8'h6D);

      reset = 1'b1; step(); reset = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         reset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 5) == 0) begin CurrentX = 10'd0; CurrentY = 9'd0; end
         else begin CurrentX = 10'($urandom_range(1, 639)); CurrentY = 9'($urandom_range(0, 479)); end
         case ($urandom_range(0, 7))
            0: begin playerX = 10'($urandom_range(0, 639)); playerY = 9'($urandom_range(0, 479)); end
            1: begin playerX = 10'($urandom_range(260, 379)); playerY = 9'($urandom_range(0, 39)); end
            2: begin playerX = 10'($urandom_range(260, 379)); playerY = 9'($urandom_range(440, 479)); end
            3: begin playerX = 10'($urandom_range(601, 639)); playerY = 9'($urandom_range(200, 279)); end
            4: begin playerX = 10'($urandom_range(0, 39)); playerY = 9'($urandom_range(200, 279)); end
            5: begin playerX = ($urandom_range(0, 1) == 0) ? 10'd259 : 10'd380; playerY = 9'($urandom_range(0, 40)); end
            6: begin playerX = 10'd600; playerY = 9'($urandom_range(199, 280)); end
            default: begin playerX = 10'($urandom_range(0, 40)); playerY = ($urandom_range(0, 1) == 0) ? 9'd199 : 9'd280; end
         endcase
         spawn_ack = ($urandom_range(0, 3) == 0);
         mapData0 = 8'($urandom); mapData1 = 8'($urandom);
         mapData2 = 8'($urandom); mapData3 = 8'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
